// File: rtl/sysid_pkg.sv
// ============================================================================
// Module   : sysid_pkg
// Brief    : Shared types and constants for the system-ID boot checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ID   = 3'd1,
        ST_WAIT_ID = 3'd2,
        ST_RD_TS   = 3'd3,
        ST_WAIT_TS = 3'd4,
        ST_CHECK   = 3'd5,
        ST_DONE    = 3'd6,
        ST_RETRY   = 3'd7
    } sysid_state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;
    localparam int   RETRY_MAX     = 3;
    localparam int   RETRY_GAP     = 16;

    // Wide enough for both the read latency (max 7) and the retry gap (16)
    localparam int   CNT_W         = 5;

endpackage : sysid_pkg

`default_nettype wire

// File: rtl/sysid_lat_counter.sv
// ============================================================================
// Module   : sysid_lat_counter
// Brief    : Loadable down-counter with a terminal-count flag (count == 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sysid_lat_counter
    import sysid_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - c_one;
        end
    end

    assign o_tc = (r_count == c_one);

endmodule : sysid_lat_counter

`default_nettype wire

// File: rtl/sysid_boot_checker.sv
// ============================================================================
// Module   : sysid_boot_checker
// Brief    : Avalon-MM read master that fetches the system ID and build
//            timestamp and compares them against expected values.
//            Optional retry loop enabled by macro SYSID_CHECK_RETRY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sysid_boot_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS  = 32'h5A79_EECA,
    parameter int          READ_LATENCY = 0,
    parameter int          AUTO_START   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        av_address,
    output logic        av_read,
    input  logic [31:0] av_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_match,
    output logic        ts_match,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [2:0]  retry_count
);

    localparam logic [CNT_W-1:0] c_lat  = CNT_W'(READ_LATENCY);
    localparam logic [CNT_W-1:0] c_gap  = CNT_W'(RETRY_GAP);
    localparam logic             c_auto = (AUTO_START != 0);

    sysid_state_t r_state;
    logic         r_auto;
    logic         r_av_address;
    logic         r_av_read;
    logic         r_busy;
    logic         r_done;
    logic         r_pass;
    logic         r_id_match;
    logic         r_ts_match;
    logic [31:0]  r_id_value;
    logic [31:0]  r_ts_value;

    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic             w_cnt_tc;
    logic [CNT_W-1:0] w_cnt_val;
    logic             w_id_ok;
    logic             w_ts_ok;

    assign w_id_ok = (r_id_value == EXPECTED_ID);
    assign w_ts_ok = (r_ts_value == EXPECTED_TS);

    // One counter serves both read-latency waits and the retry gap
    always_comb begin
        w_cnt_load = (r_state == ST_RD_ID) || (r_state == ST_RD_TS) || (r_state == ST_CHECK);
        w_cnt_val  = (r_state == ST_CHECK) ? c_gap : c_lat;
        w_cnt_dec  = (r_state == ST_WAIT_ID) || (r_state == ST_WAIT_TS) || (r_state == ST_RETRY);
    end

    sysid_lat_counter #(
        .WIDTH      (CNT_W)
    ) u_lat_counter (
        .clk        (clock),
        .rst        (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_tc       (w_cnt_tc)
    );

`ifdef SYSID_CHECK_RETRY_EN
    localparam logic [2:0] c_retry_max = 3'(RETRY_MAX);
    logic [2:0] r_retry;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_auto       <= c_auto;
            r_av_address <= 1'b0;
            r_av_read    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_id_match   <= 1'b0;
            r_ts_match   <= 1'b0;
            r_id_value   <= '0;
            r_ts_value   <= '0;
`ifdef SYSID_CHECK_RETRY_EN
            r_retry      <= '0;
`endif
        end else begin
            r_auto <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start || r_auto) begin
                        r_state      <= ST_RD_ID;
                        r_av_read    <= 1'b1;
                        r_av_address <= SYSID_ADDR_ID;
                        r_busy       <= 1'b1;
`ifdef SYSID_CHECK_RETRY_EN
                        r_retry      <= '0;
`endif
                    end
                end
                ST_RD_ID: begin
                    if (READ_LATENCY == 0) begin
                        r_id_value   <= av_readdata;
                        r_state      <= ST_RD_TS;
                        r_av_address <= SYSID_ADDR_TS;
                    end else begin
                        r_av_read    <= 1'b0;
                        r_state      <= ST_WAIT_ID;
                    end
                end
                ST_WAIT_ID: begin
                    if (w_cnt_tc) begin
                        r_id_value   <= av_readdata;
                        r_state      <= ST_RD_TS;
                        r_av_read    <= 1'b1;
                        r_av_address <= SYSID_ADDR_TS;
                    end
                end
                ST_RD_TS: begin
                    r_av_read <= 1'b0;
                    if (READ_LATENCY == 0) begin
                        r_ts_value <= av_readdata;
                        r_state    <= ST_CHECK;
                    end else begin
                        r_state    <= ST_WAIT_TS;
                    end
                end
                ST_WAIT_TS: begin
                    if (w_cnt_tc) begin
                        r_ts_value <= av_readdata;
                        r_state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_id_match <= w_id_ok;
                    r_ts_match <= w_ts_ok;
                    r_pass     <= w_id_ok && w_ts_ok;
`ifdef SYSID_CHECK_RETRY_EN
                    if (!(w_id_ok && w_ts_ok) && (r_retry < c_retry_max)) begin
                        r_retry <= r_retry + 3'd1;
                        r_state <= ST_RETRY;
                    end else
`endif
                    begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
`ifdef SYSID_CHECK_RETRY_EN
                ST_RETRY: begin
                    if (w_cnt_tc) begin
                        r_state      <= ST_RD_ID;
                        r_av_read    <= 1'b1;
                        r_av_address <= SYSID_ADDR_ID;
                    end
                end
`endif
                ST_DONE: begin
                    if (start) begin
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_id_match   <= 1'b0;
                        r_ts_match   <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_RD_ID;
                        r_av_read    <= 1'b1;
                        r_av_address <= SYSID_ADDR_ID;
`ifdef SYSID_CHECK_RETRY_EN
                        r_retry      <= '0;
`endif
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign av_address = r_av_address;
    assign av_read    = r_av_read;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign id_match   = r_id_match;
    assign ts_match   = r_ts_match;
    assign id_value   = r_id_value;
    assign ts_value   = r_ts_value;
`ifdef SYSID_CHECK_RETRY_EN
    assign retry_count = r_retry;
`else
    assign retry_count = 3'd0;
`endif

endmodule : sysid_boot_checker

`default_nettype wire

// File: tb/tb_sysid_boot_checker.sv
// ============================================================================
// Module   : tb_sysid_boot_checker
// Brief    : Self-checking bench for sysid_boot_checker (three configurations).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sysid_boot_checker;

    localparam logic [31:0] c_exp_id = 32'h0000_0000;
    localparam logic [31:0] c_exp_ts = 32'h5A79_EECA;
    localparam logic [31:0] c_id_c   = 32'h1234_5678;
`ifdef SYSID_CHECK_RETRY_EN
    localparam bit c_retry = 1'b1;
`else
    localparam bit c_retry = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst_c;
    logic start_a, start_b, start_c;
    logic addr_a, addr_b, addr_c, read_a, read_b, read_c;
    logic busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
    logic idm_a, idm_b, idm_c, tsm_a, tsm_b, tsm_c;
    logic [31:0] rd_a, rd_b, rd_c, idv_a, idv_b, idv_c, tsv_a, tsv_b, tsv_c;
    logic [2:0]  rc_a, rc_b, rc_c;

    // Slave models: data only valid exactly READ_LATENCY cycles after issue
    logic [31:0] mem_a [2];
    logic [31:0] mem_b [2];
    logic [31:0] mem_c [2];
    logic [1:0]  pipe_b [3];
    logic [1:0]  pipe_c [2];

    assign rd_a = read_a ? mem_a[addr_a] : 32'hBAD0_000A;
    assign rd_b = pipe_b[2][1] ? mem_b[pipe_b[2][0]] : 32'hBAD0_000B;
    assign rd_c = pipe_c[1][1] ? mem_c[pipe_c[1][0]] : 32'hBAD0_000C;

    int reads_a = 0, reads_b = 0, rises_b = 0;
    logic done_b_q = 1'b0;

    always @(posedge clk) begin
        pipe_b[0] <= {read_b, addr_b};
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
        pipe_c[0] <= {read_c, addr_c};
        pipe_c[1] <= pipe_c[0];
        if (read_a === 1'b1) reads_a <= reads_a + 1;
        if (read_b === 1'b1) reads_b <= reads_b + 1;
        done_b_q <= done_b;
        if ((done_b === 1'b1) && !done_b_q) rises_b <= rises_b + 1;
    end

    sysid_boot_checker #(.EXPECTED_ID(c_exp_id), .EXPECTED_TS(c_exp_ts),
                         .READ_LATENCY(0), .AUTO_START(1)) u_dut_a (
        .clock(clk), .reset(rst), .start(start_a), .av_address(addr_a), .av_read(read_a),
        .av_readdata(rd_a), .busy(busy_a), .done(done_a), .pass(pass_a), .id_match(idm_a),
        .ts_match(tsm_a), .id_value(idv_a), .ts_value(tsv_a), .retry_count(rc_a));

    sysid_boot_checker #(.EXPECTED_ID(c_exp_id), .EXPECTED_TS(c_exp_ts),
                         .READ_LATENCY(3), .AUTO_START(0)) u_dut_b (
        .clock(clk), .reset(rst), .start(start_b), .av_address(addr_b), .av_read(read_b),
        .av_readdata(rd_b), .busy(busy_b), .done(done_b), .pass(pass_b), .id_match(idm_b),
        .ts_match(tsm_b), .id_value(idv_b), .ts_value(tsv_b), .retry_count(rc_b));

    sysid_boot_checker #(.EXPECTED_ID(c_id_c), .EXPECTED_TS(c_exp_ts),
                         .READ_LATENCY(2), .AUTO_START(1)) u_dut_c (
        .clock(clk), .reset(rst_c), .start(start_c), .av_address(addr_c), .av_read(read_c),
        .av_readdata(rd_c), .busy(busy_c), .done(done_c), .pass(pass_c), .id_match(idm_c),
        .ts_match(tsm_c), .id_value(idv_c), .ts_value(tsv_c), .retry_count(rc_c));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] idw;
        logic [31:0] tsw;
        logic        exp_idm;
        logic        exp_tsm;
        logic        exp_pass;
    } vec_t;

    vec_t vecs [5];

    // Reference: check length from accepted start to done, in cycles
    function automatic int check_len(input int lat, input bit ok);
        int base;
        base = 2 * (lat + 1) + 1;
        return (ok || !c_retry) ? base : base + 3 * (16 + base);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int e, r0, d0, n, m_end, k;
        bit s, m_active, m_ok;
        logic [31:0] m_id, m_ts;

        vecs[0] = '{c_exp_id,      c_exp_ts,      1'b1, 1'b1, 1'b1};
        vecs[1] = '{c_exp_id,      32'hDEADBEEF,  1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0001, c_exp_ts,      1'b0, 1'b1, 1'b0};
        vecs[3] = '{c_exp_id,      c_exp_ts,      1'b1, 1'b1, 1'b1};
        vecs[4] = '{32'h8000_0000, 32'h5A79_EECB, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 3; i++) begin
            pipe_b[i] = 2'b00;
        end
        pipe_c[0] = 2'b00;
        pipe_c[1] = 2'b00;
        rst = 1'b1; rst_c = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        mem_a[0] = c_exp_id; mem_a[1] = c_exp_ts;
        mem_b[0] = c_exp_id; mem_b[1] = c_exp_ts;
        mem_c[0] = c_id_c;   mem_c[1] = c_exp_ts;
        repeat (3) @(negedge clk);

        chk("rst_a_busy", busy_a, 0);  chk("rst_a_done", done_a, 0);
        chk("rst_a_read", read_a, 0);  chk("rst_a_pass", pass_a, 0);
        chk("rst_b_idv", idv_b, 0);    chk("rst_b_rc", rc_b, 0);

        // A: auto-start on the first post-reset edge; done 3 cycles later
        rst = 1'b0;
        r0 = reads_a;
        e = 0;
        while (!done_a && e < 50) begin
            @(negedge clk);
            e++;
        end
        chk("a_auto_done_edge", e, 4);
        chk("a_pass", pass_a, 1);      chk("a_idv", idv_a, c_exp_id);
        chk("a_tsv", tsv_a, c_exp_ts); chk("a_idm", idm_a, 1);
        chk("a_tsm", tsm_a, 1);        chk("a_busy", busy_a, 0);
        chk("a_reads", reads_a - r0, 2);

        // B: no auto start
        repeat (10) @(negedge clk);
        chk("b_no_auto_reads", reads_b, 0);
        chk("b_no_auto_busy", busy_b, 0);

        for (int i = 0; i < 5; i++) begin
            mem_b[0] = vecs[i].idw;
            mem_b[1] = vecs[i].tsw;
            r0 = reads_b;
            start_b = 1'b1;
            @(negedge clk);
            start_b = 1'b0;
            chk($sformatf("b%0d_clr_done", i), done_b, 0);
            chk($sformatf("b%0d_clr_pass", i), pass_b, 0);
            chk($sformatf("b%0d_busy", i), busy_b, 1);
            e = 0;
            while (!done_b && e < 300) begin
                @(negedge clk);
                e++;
            end
            chk($sformatf("b%0d_lat", i), e, check_len(3, vecs[i].exp_pass));
            chk($sformatf("b%0d_pass", i), pass_b, vecs[i].exp_pass);
            chk($sformatf("b%0d_idm", i), idm_b, vecs[i].exp_idm);
            chk($sformatf("b%0d_tsm", i), tsm_b, vecs[i].exp_tsm);
            chk($sformatf("b%0d_idv", i), idv_b, vecs[i].idw);
            chk($sformatf("b%0d_tsv", i), tsv_b, vecs[i].tsw);
            chk($sformatf("b%0d_reads", i), reads_b - r0,
                (vecs[i].exp_pass || !c_retry) ? 2 : 8);
            chk($sformatf("b%0d_rc", i), rc_b, (vecs[i].exp_pass || !c_retry) ? 0 : 3);
            @(negedge clk);
        end

        // B: starts during WAIT_ID and during CHECK are ignored
        mem_b[0] = c_exp_id; mem_b[1] = c_exp_ts;
        r0 = reads_b; d0 = rises_b;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (6) @(negedge clk);
        chk("b_ign_check_busy", busy_b, 1);
        chk("b_ign_check_done", done_b, 0);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("b_ign_done", done_b, 1);
        repeat (20) @(negedge clk);
        chk("b_ign_reads", reads_b - r0, 2);
        chk("b_ign_rises", rises_b - d0, 1);
        chk("b_ign_pass", pass_b, 1);

        // C: reset during WAIT_TS of the auto-started check
        @(negedge clk);
        rst_c = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("c_pre_busy", busy_c, 1);
        chk("c_pre_read", read_c, 0);
        chk("c_pre_addr", addr_c, 1);
        chk("c_pre_idv", idv_c, c_id_c);
        rst_c = 1'b1;
        #1;
        chk("c_rst_busy", busy_c, 0);   chk("c_rst_addr", addr_c, 0);
        chk("c_rst_idv", idv_c, 0);     chk("c_rst_read", read_c, 0);
        repeat (2) @(negedge clk);
        rst_c = 1'b0;

        // C: randomized starts and slave contents against a transaction model
        n = 0; m_active = 1'b0; m_end = 0; m_ok = 1'b0; m_id = '0; m_ts = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            s = ($urandom_range(0, 9) == 0);
            if (!(m_active && n < m_end) && (cyc > 0)) begin
                k = $urandom_range(0, 5);
                mem_c[0] = c_id_c;
                mem_c[1] = c_exp_ts;
                if (k == 3) mem_c[0] = c_id_c ^ (32'h1 << $urandom_range(0, 31));
                else if (k == 4) mem_c[1] = $urandom();
                else if (k == 5) begin
                    mem_c[0] = $urandom();
                    mem_c[1] = c_exp_ts ^ 32'h8000_0000;
                end
            end
            start_c = s;
            @(posedge clk);
            n++;
            if ((n == 1) || (s && (!m_active || n > m_end))) begin
                m_active = 1'b1;
                m_id = mem_c[0];
                m_ts = mem_c[1];
                m_ok = (m_id == c_id_c) && (m_ts == c_exp_ts);
                m_end = n + check_len(2, m_ok);
            end
            #1;
            chk("c_rand_busy", busy_c, m_active && (n < m_end));
            chk("c_rand_done", done_c, m_active && (n >= m_end));
            if (m_active && (n >= m_end)) begin
                chk("c_rand_pass", pass_c, m_ok);
                chk("c_rand_idm", idm_c, m_id == c_id_c);
                chk("c_rand_tsm", tsm_c, m_ts == c_exp_ts);
                chk("c_rand_idv", idv_c, m_id);
                chk("c_rand_tsv", tsv_c, m_ts);
                chk("c_rand_rc", rc_c, (m_ok || !c_retry) ? 0 : 3);
            end
            @(negedge clk);
        end
        start_c = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sysid_boot_checker

`default_nettype wire
